mem_access_unit: RTL and testbench

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_pkg.sv | 25 ++
 rtl/mem_timeout_ctr.sv | 25 ++
 rtl/mem_access_unit.sv | 136 +++++++++++++
 tb/tb_mem_access_unit.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types and constants for the MEM-stage data-memory access unit.
package mem_pkg;

  localparam int TIMEOUT_CYCLES_DEFAULT = 15;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_DONE
  } mem_state_e;

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_MISALIGN = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT  = 2'd2;
  localparam logic [1:0] ERR_ILLEGAL  = 2'd3;

  typedef struct packed {
    logic        reg_write;
    logic        mem_to_reg;
    logic [4:0]  rd;
    logic [63:0] read_data;
    logic [63:0] result;
  } mw_t;

endpackage

// File: rtl/mem_timeout_ctr.sv
// Cycle counter for an outstanding memory request; expired flags the cycle
// on which the count would reach the limit.
module mem_timeout_ctr #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         enable,
  input  logic [W-1:0] limit,
  output logic         expired
);

  logic [W-1:0] cnt;
  logic [W:0]   cnt_nxt;

  assign cnt_nxt = {1'b0, cnt} + {{W{1'b0}}, 1'b1};
  assign expired = (cnt_nxt == {1'b0, limit});

  always_ff @(posedge clk) begin
    if (reset || clear) cnt <= '0;
    else if (enable)    cnt <= cnt_nxt[W-1:0];
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM stage: drives a handshaked data-memory port, stalls the front of the
// pipeline while a request is outstanding, and owns the MEM/WB register.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        EM_MemRead,
  input  logic        EM_MemWrite,
  input  logic        EM_MemtoReg,
  input  logic        EM_RegWrite,
  input  logic [4:0]  EM_RD,
  input  logic [63:0] EM_Result,
  input  logic [63:0] EM_WriteData,
  output logic        mem_req,
  output logic        mem_we,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [63:0] mem_rdata,
  output logic        stall,
  output logic        MW_RegWrite,
  output logic        MW_MemtoReg,
  output logic [4:0]  MW_RD,
  output logic [63:0] MW_ReadData,
  output logic [63:0] MW_Result,
  output logic        mem_err,
  output logic [1:0]  mem_err_code
);

  localparam logic [7:0] LIMIT = 8'(TIMEOUT_CYCLES);

  mem_state_e  state, state_n;
  logic        is_mem, illegal, misalign, access;
  logic        ctr_clear, ctr_en, expired;
  logic [1:0]  fault_code;
  logic [63:0] rdata_q;
  logic        timed_out;
  mw_t         mw;

  assign is_mem   = EM_MemRead | EM_MemWrite;
  assign illegal  = EM_MemRead & EM_MemWrite;
  assign misalign = is_mem & (EM_Result[2:0] != 3'b000);
  assign access   = (EM_MemRead ^ EM_MemWrite) & ~misalign;

  mem_timeout_ctr #(.W(8)) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .clear   (ctr_clear),
    .enable  (ctr_en),
    .limit   (LIMIT),
    .expired (expired)
  );

  always_comb begin
    state_n    = state;
    stall      = 1'b0;
    ctr_clear  = 1'b0;
    ctr_en     = 1'b0;
    fault_code = ERR_NONE;
    unique case (state)
      ST_IDLE: begin
        if (access) begin
          state_n   = ST_REQ;
          stall     = 1'b1;
          ctr_clear = 1'b1;
        end else if (illegal) begin
          fault_code = ERR_ILLEGAL;
        end else if (misalign) begin
          fault_code = ERR_MISALIGN;
        end
      end
      ST_REQ: begin
        stall  = 1'b1;
        ctr_en = ~mem_ack;
        // ack takes priority over a simultaneous expiry
        if (mem_ack || expired) state_n = ST_DONE;
      end
      ST_DONE: begin
        // EX/MEM still holds the finished access, so no re-detection here
        state_n = ST_IDLE;
        if (timed_out) fault_code = ERR_TIMEOUT;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      rdata_q      <= '0;
      timed_out    <= 1'b0;
      mw           <= '0;
      mem_err      <= 1'b0;
      mem_err_code <= ERR_NONE;
    end else begin
      state <= state_n;
      if (state == ST_IDLE && access) begin
        mem_req   <= 1'b1;
        mem_we    <= EM_MemWrite;
        mem_addr  <= EM_Result;
        mem_wdata <= EM_WriteData;
      end else if (state == ST_REQ && state_n == ST_DONE) begin
        mem_req   <= 1'b0;
        mem_we    <= 1'b0;
        timed_out <= ~mem_ack;
        rdata_q   <= (mem_ack && EM_MemRead) ? mem_rdata : '0;
      end
      if (!stall) begin
        mw.reg_write  <= EM_RegWrite & (fault_code == ERR_NONE);
        mw.mem_to_reg <= EM_MemtoReg;
        mw.rd         <= EM_RD;
        mw.read_data  <= (state == ST_DONE) ? rdata_q : '0;
        mw.result     <= EM_Result;
        mem_err       <= (fault_code != ERR_NONE);
        mem_err_code  <= fault_code;
      end else begin
        mem_err      <= 1'b0;
        mem_err_code <= ERR_NONE;
      end
    end
  end

  assign MW_RegWrite = mw.reg_write;
  assign MW_MemtoReg = mw.mem_to_reg;
  assign MW_RD       = mw.rd;
  assign MW_ReadData = mw.read_data;
  assign MW_Result   = mw.result;

endmodule

// File: tb/tb_mem_access_unit.sv
// Instruction-level bench for mem_access_unit: each instruction is held in
// EX/MEM while stalled, a memory responder acks after a chosen delay, and the
// outcome is compared to what the access rules predict.
module tb_mem_access_unit;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        EM_MemRead, EM_MemWrite, EM_MemtoReg, EM_RegWrite;
  logic [4:0]  EM_RD;
  logic [63:0] EM_Result, EM_WriteData;
  logic        mem_req, mem_we;
  logic [63:0] mem_addr, mem_wdata;
  logic        mem_ack;
  logic [63:0] mem_rdata;
  logic        stall;
  logic        MW_RegWrite, MW_MemtoReg;
  logic [4:0]  MW_RD;
  logic [63:0] MW_ReadData, MW_Result;
  logic        mem_err;
  logic [1:0]  mem_err_code;

  int n_cmp = 0;
  int n_bad = 0;

  mem_access_unit #(.TIMEOUT_CYCLES(TO)) dut (
    .clk          (clk),
    .reset        (reset),
    .EM_MemRead   (EM_MemRead),
    .EM_MemWrite  (EM_MemWrite),
    .EM_MemtoReg  (EM_MemtoReg),
    .EM_RegWrite  (EM_RegWrite),
    .EM_RD        (EM_RD),
    .EM_Result    (EM_Result),
    .EM_WriteData (EM_WriteData),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_ack      (mem_ack),
    .mem_rdata    (mem_rdata),
    .stall        (stall),
    .MW_RegWrite  (MW_RegWrite),
    .MW_MemtoReg  (MW_MemtoReg),
    .MW_RD        (MW_RD),
    .MW_ReadData  (MW_ReadData),
    .MW_Result    (MW_Result),
    .mem_err      (mem_err),
    .mem_err_code (mem_err_code)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_em(input logic rd, input logic wr, input logic mtr, input logic rw,
                        input logic [4:0] rdn, input logic [63:0] res, input logic [63:0] wd);
    EM_MemRead = rd; EM_MemWrite = wr; EM_MemtoReg = mtr; EM_RegWrite = rw;
    EM_RD = rdn; EM_Result = res; EM_WriteData = wd;
  endtask

  // Called at posedge+1. delay = REQ cycle (1-based) on which memory acks.
  task automatic run_instr(input logic rd, input logic wr, input logic mtr, input logic rw,
                           input logic [4:0] rdn, input logic [63:0] res, input logic [63:0] wd,
                           input logic [63:0] rdat, input int delay, input bit noise);
    int stalls = 0, reqs = 0, cyc = 0;
    bit retired = 0, port_ok = 1, err_quiet = 1, was_stall;
    int exp_code, exp_reqs, exp_stalls;
    logic exp_rw;
    logic [63:0] exp_rdata;

    exp_reqs = 0; exp_rw = rw; exp_rdata = '0;
    if (rd && wr)                          exp_code = 3;
    else if ((rd || wr) && res[2:0] != 0)  exp_code = 1;
    else if (rd || wr) begin
      if (delay <= TO) begin
        exp_code = 0; exp_reqs = delay;
        if (rd) exp_rdata = rdat;
      end else begin
        exp_code = 2; exp_reqs = TO;
      end
    end else exp_code = 0;
    if (exp_code != 0) exp_rw = 1'b0;
    exp_stalls = (exp_code == 0 && (rd || wr)) || exp_code == 2 ? exp_reqs + 1 : 0;

    set_em(rd, wr, mtr, rw, rdn, res, wd);
    while (!retired && cyc < 200) begin
      @(negedge clk);
      if (mem_req) begin
        reqs++;
        if (mem_we !== wr || mem_addr !== res || mem_wdata !== wd) port_ok = 0;
      end
      mem_ack   = mem_req ? (reqs == delay) : (noise && $urandom_range(0, 1) == 1);
      mem_rdata = (mem_req && mem_ack) ? rdat : {$urandom, $urandom};
      was_stall = stall;
      if (stall) stalls++; else retired = 1;
      @(posedge clk); #1;
      mem_ack = 1'b0;
      if (was_stall && mem_err !== 1'b0) err_quiet = 0;
      cyc++;
    end
    chk("retired", 64'(retired), 64'd1);
    chk("stall_cycles", 64'(stalls), 64'(exp_stalls));
    chk("req_cycles", 64'(reqs), 64'(exp_reqs));
    chk("req_port_stable", 64'(port_ok), 64'd1);
    chk("err_low_while_stalled", 64'(err_quiet), 64'd1);
    chk("MW_RegWrite", 64'(MW_RegWrite), 64'(exp_rw));
    chk("MW_MemtoReg", 64'(MW_MemtoReg), 64'(mtr));
    chk("MW_RD", 64'(MW_RD), 64'(rdn));
    chk("MW_Result", MW_Result, res);
    chk("MW_ReadData", MW_ReadData, exp_rdata);
    chk("mem_err", 64'(mem_err), 64'(exp_code != 0));
    chk("mem_err_code", 64'(mem_err_code), 64'(exp_code));
  endtask

  initial begin
    logic [63:0] r;
    int kind;
    bit w;

    reset = 1'b1; mem_ack = 1'b0; mem_rdata = '0;
    set_em(0, 0, 0, 0, 5'd0, 64'd0, 64'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mem_req", 64'(mem_req), 64'd0);
    chk("rst_mem_we", 64'(mem_we), 64'd0);
    chk("rst_mem_addr", mem_addr, 64'd0);
    chk("rst_mem_wdata", mem_wdata, 64'd0);
    chk("rst_MW_RegWrite", 64'(MW_RegWrite), 64'd0);
    chk("rst_MW_ReadData", MW_ReadData, 64'd0);
    chk("rst_MW_Result", MW_Result, 64'd0);
    chk("rst_mem_err", {62'd0, mem_err_code}, 64'd0);
    chk("rst_stall", 64'(stall), 64'd0);
    reset = 1'b0;

    // directed corners
    run_instr(1, 0, 1, 1, 5'd7,  64'h100, 64'h0,  64'hDEADBEEF, 1, 0);
    run_instr(0, 1, 0, 0, 5'd3,  64'h208, 64'h55, 64'h1234, 3, 0);
    run_instr(1, 0, 1, 1, 5'd9,  64'h400, 64'h0,  64'h77, 99, 0);
    run_instr(1, 0, 1, 1, 5'd10, 64'h408, 64'h0,  64'h88, TO, 0);
    run_instr(1, 0, 1, 1, 5'd11, 64'h103, 64'h0,  64'h99, 1, 0);
    run_instr(1, 1, 0, 1, 5'd12, 64'h110, 64'h0,  64'h99, 1, 0);
    run_instr(0, 0, 0, 1, 5'd13, 64'h5,   64'h0,  64'h0, 1, 0);
    run_instr(1, 0, 1, 1, 5'd14, 64'h500, 64'h0,  64'hAAAA, 1, 0);
    run_instr(1, 0, 1, 1, 5'd15, 64'h508, 64'h0,  64'hBBBB, 1, 0);

    // reset arriving on the second REQ cycle
    set_em(1, 0, 1, 1, 5'd20, 64'h300, 64'h0);
    @(negedge clk); @(posedge clk); #1;
    @(negedge clk); @(posedge clk); #1;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("rstreq_mem_req", 64'(mem_req), 64'd0);
    chk("rstreq_MW_RegWrite", 64'(MW_RegWrite), 64'd0);
    chk("rstreq_MW_RD", 64'(MW_RD), 64'd0);
    chk("rstreq_MW_Result", MW_Result, 64'd0);
    chk("rstreq_stall_from_idle", 64'(stall), 64'd1);
    set_em(0, 0, 0, 0, 5'd0, 64'd0, 64'd0);
    reset = 1'b0;
    @(negedge clk);
    mem_ack = 1'b1; mem_rdata = 64'hFEEDFACE;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    chk("late_ack_mem_req", 64'(mem_req), 64'd0);
    chk("late_ack_ReadData", MW_ReadData, 64'd0);
    chk("late_ack_err", 64'(mem_err), 64'd0);

    // randomized instruction stream with ack noise
    for (int i = 0; i < 150; i++) begin
      kind = $urandom_range(0, 9);
      r = {$urandom, $urandom};
      r[2:0] = 3'b000;
      w = $urandom_range(0, 1) == 1;
      if (kind == 6) r[2:0] = 3'($urandom_range(1, 7));
      case (kind)
        0, 1, 2, 3: run_instr(1, 0, 1, 1'($urandom), 5'($urandom), r, 64'h0,
                              {$urandom, $urandom}, $urandom_range(1, 6), 1);
        4, 5:       run_instr(0, 1, 0, 1'($urandom), 5'($urandom), r, {$urandom, $urandom},
                              {$urandom, $urandom}, $urandom_range(1, 6), 1);
        6:          run_instr(~w, w, 1'($urandom), 1, 5'($urandom), r, 64'h0,
                              64'h0, 1, 1);
        7:          run_instr(1, 1, 1'($urandom), 1, 5'($urandom), r, 64'h0,
                              64'h0, 1, 1);
        default:    run_instr(0, 0, 1'($urandom), 1'($urandom), 5'($urandom), r, 64'h0,
                              64'h0, 1, 1);
      endcase
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
